// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared constants and types for the instruction fetch slice.
//   - HALT_INSTR / NOP_INSTR : reserved instruction encodings
//   - ifetch_state_e         : fetch FSM state encoding (LOAD, RUN, HALTED)
//   - DEFAULT_*              : default parameter values for instruction_fetch
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int DEFAULT_PC_SIZE          = 32;
  localparam int DEFAULT_INSTRUCTION_SIZE = 32;
  localparam int DEFAULT_MEM_DEPTH        = 256;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/instruction_fetch_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
//   Instruction storage: one synchronous write port, one asynchronous read
//   port. Contents are never reset.
//   Ports:
//     i_clk    : write clock (rising edge)
//     i_we     : write enable
//     i_waddr  : write word address
//     i_wdata  : write data
//     i_raddr  : read word address
//     o_rdata  : read data, combinational from i_raddr
// -----------------------------------------------------------------------------
module instruction_memory #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage with an internal loadable instruction memory.
//   The FSM starts in LOAD (program download), moves to RUN on i_load_done,
//   and parks in HALTED after fetching the HALT instruction. i_load_start
//   restarts a download from any state.
//
//   Optional build macro:
//     IFETCH_BYTE_LOAD_EN : load beats carry one byte (i_load_data[7:0]);
//                           four beats form one little-endian word.
//
//   Ports:
//     i_clk, i_reset_n      : clock (rising edge), async active-low reset
//     i_enable              : global run enable
//     i_stall               : hazard hold, PC frozen
//     i_branch_taken/_pc    : taken branch and its target (highest priority)
//     i_jump/i_jump_pc      : jump and its target
//     i_load_start          : enter LOAD, clear write pointer and PC
//     i_load_valid/_data    : load beat
//     i_load_done           : leave LOAD for RUN
//     o_pc, o_next_seq_pc   : current PC and PC+4
//     o_instruction         : instruction at o_pc (zero-latency read)
//     o_halt                : HALT fetched in RUN, or FSM in HALTED
//     o_flush               : redirect request to IF/ID (combinational)
//     o_mem_full            : write pointer reached MEM_DEPTH
//
//   Load handshake: there is no backpressure. A beat is taken on every rising
//   edge where the FSM is in LOAD, i_load_valid is high and i_load_start is
//   low. Once o_mem_full is high, completed words are silently dropped.
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PC_SIZE          = DEFAULT_PC_SIZE,
  parameter int INSTRUCTION_SIZE = DEFAULT_INSTRUCTION_SIZE,
  parameter int MEM_DEPTH        = DEFAULT_MEM_DEPTH
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_enable,
  input  logic                        i_stall,
  input  logic                        i_branch_taken,
  input  logic [PC_SIZE-1:0]          i_branch_pc,
  input  logic                        i_jump,
  input  logic [PC_SIZE-1:0]          i_jump_pc,
  input  logic                        i_load_start,
  input  logic                        i_load_valid,
  input  logic [INSTRUCTION_SIZE-1:0] i_load_data,
  input  logic                        i_load_done,
  output logic [PC_SIZE-1:0]          o_next_seq_pc,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_halt,
  output logic                        o_flush,
  output logic                        o_mem_full,
  output logic [PC_SIZE-1:0]          o_pc
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  // One extra bit so the pointer can sit at MEM_DEPTH instead of wrapping.
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [INSTRUCTION_SIZE-1:0] HALT_WORD = INSTRUCTION_SIZE'(HALT_INSTR);

  ifetch_state_e               state_q, state_d;
  logic [PC_SIZE-1:0]          pc_q, pc_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic                        mem_full;
  logic                        mem_we;
  logic [INSTRUCTION_SIZE-1:0] mem_wdata;
  logic [INSTRUCTION_SIZE-1:0] mem_rdata;
  logic                        pc_in_range;
  logic                        is_halt;
  logic                        load_beat;
  logic                        word_ready;
  logic [INSTRUCTION_SIZE-1:0] load_word;

  // A restart request overrides any beat presented in the same cycle.
  assign load_beat = (state_q == ST_LOAD) && i_load_valid && !i_load_start;

`ifdef IFETCH_BYTE_LOAD_EN
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] byte_buf_q, byte_buf_d;
  logic        unused_load_hi;

  assign unused_load_hi = ^i_load_data[INSTRUCTION_SIZE-1:8];

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    byte_buf_d = byte_buf_q;
    word_ready = 1'b0;
    // The 4th byte goes straight into the top lane; the first three wait here.
    load_word  = INSTRUCTION_SIZE'({i_load_data[7:0], byte_buf_q});
    if (load_beat) begin
      case (byte_cnt_q)
        2'd0:    byte_buf_d[7:0]   = i_load_data[7:0];
        2'd1:    byte_buf_d[15:8]  = i_load_data[7:0];
        2'd2:    byte_buf_d[23:16] = i_load_data[7:0];
        default: word_ready        = 1'b1;
      endcase
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
    // Restart or end of load throws away any partially assembled word.
    if (i_load_start || ((state_q == ST_LOAD) && i_load_done)) begin
      byte_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      byte_cnt_q <= 2'd0;
      byte_buf_q <= 24'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      byte_buf_q <= byte_buf_d;
    end
  end
`else
  assign word_ready = load_beat;
  assign load_word  = i_load_data;
`endif

  assign mem_full  = (wr_ptr_q == PTR_W'(MEM_DEPTH));
  // Gating with i_reset_n keeps a clock edge during reset from writing.
  assign mem_we    = word_ready && !mem_full && i_reset_n;
  assign mem_wdata = mem_we ? load_word : INSTRUCTION_SIZE'(NOP_INSTR);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (i_load_start) begin
      wr_ptr_d = '0;
    end else if (mem_we) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
  end

  instruction_memory #(
    .DATA_W (INSTRUCTION_SIZE),
    .DEPTH  (MEM_DEPTH)
  ) u_imem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q[ADDR_W-1:0]),
    .i_wdata (mem_wdata),
    .i_raddr (pc_q[ADDR_W+1:2]),
    .o_rdata (mem_rdata)
  );

  // Addresses past the end of memory read as HALT so runaway code stops.
  assign pc_in_range   = ((pc_q >> (ADDR_W + 2)) == '0);
  assign o_instruction = pc_in_range ? mem_rdata : HALT_WORD;
  assign is_halt       = (o_instruction == HALT_WORD);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (i_load_start) begin
      state_d = ST_LOAD;
      pc_d    = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (i_load_done) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // A redirect beats HALT: the halting instruction was on a dead path.
          if (i_enable && !i_stall) begin
            if (i_branch_taken) begin
              pc_d = i_branch_pc;
            end else if (i_jump) begin
              pc_d = i_jump_pc;
            end else if (is_halt) begin
              state_d = ST_HALTED;
            end else begin
              pc_d = pc_q + PC_SIZE'(4);
            end
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_LOAD;
      pc_q     <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Flush ignores i_stall so IF/ID drops the wrong-path word while held.
  assign o_flush       = (state_q == ST_RUN) && i_enable && (i_branch_taken || i_jump);
  assign o_halt        = (state_q == ST_HALTED) || ((state_q == ST_RUN) && is_halt);
  assign o_mem_full    = mem_full;
  assign o_pc          = pc_q;
  assign o_next_seq_pc = pc_q + PC_SIZE'(4);

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch with a cycle-level reference model
//   (program array, PC, mode, write count) and a compare process that checks
//   every output on every falling edge, plus literal expectations per scenario.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int PC_SIZE = 32;
  localparam int IW      = 32;
  localparam int DEPTH   = 256;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_enable, i_stall;
  logic              i_branch_taken, i_jump;
  logic [PC_SIZE-1:0] i_branch_pc, i_jump_pc;
  logic              i_load_start, i_load_valid, i_load_done;
  logic [IW-1:0]     i_load_data;
  logic [PC_SIZE-1:0] o_next_seq_pc, o_pc;
  logic [IW-1:0]     o_instruction;
  logic              o_halt, o_flush, o_mem_full;

  always #5 i_clk = ~i_clk;

  instruction_fetch #(
    .PC_SIZE          (PC_SIZE),
    .INSTRUCTION_SIZE (IW),
    .MEM_DEPTH        (DEPTH)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_enable       (i_enable),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_branch_pc    (i_branch_pc),
    .i_jump         (i_jump),
    .i_jump_pc      (i_jump_pc),
    .i_load_start   (i_load_start),
    .i_load_valid   (i_load_valid),
    .i_load_data    (i_load_data),
    .i_load_done    (i_load_done),
    .o_next_seq_pc  (o_next_seq_pc),
    .o_instruction  (o_instruction),
    .o_halt         (o_halt),
    .o_flush        (o_flush),
    .o_mem_full     (o_mem_full),
    .o_pc           (o_pc)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] prog_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode;
  logic [31:0] m_pc;
  int          m_wp;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [7:0]  m_bytes[$];

  function automatic logic [31:0] m_instr();
    if (m_pc >= DEPTH * 4) return HALT_W;
    return m_mem[m_pc / 4];
  endfunction

  function automatic bit m_instr_known();
    if (m_pc >= DEPTH * 4) return 1'b1;
    return m_known[m_pc / 4];
  endfunction

  task automatic m_reset();
    m_mode = M_LOAD;
    m_pc   = 32'd0;
    m_wp   = 0;
    m_bytes.delete();
  endtask

  task automatic m_write(input logic [31:0] w);
    if (m_wp < DEPTH) begin
      m_mem[m_wp]   = w;
      m_known[m_wp] = 1'b1;
      m_wp++;
    end
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic m_step();
    if (!i_reset_n) return;
    if (i_load_start) begin
      m_mode = M_LOAD;
      m_pc   = 32'd0;
      m_wp   = 0;
      m_bytes.delete();
      return;
    end
    if (m_mode == M_LOAD) begin
      if (i_load_valid) begin
`ifdef IFETCH_BYTE_LOAD_EN
        m_bytes.push_back(i_load_data[7:0]);
        if (m_bytes.size() == 4) begin
          m_write({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
          m_bytes.delete();
        end
`else
        m_write(i_load_data);
`endif
      end
      if (i_load_done) begin
        m_mode = M_RUN;
        m_bytes.delete();
      end
    end else if (m_mode == M_RUN) begin
      if (i_enable && !i_stall) begin
        if (i_branch_taken)        m_pc = i_branch_pc;
        else if (i_jump)           m_pc = i_jump_pc;
        else if (m_instr() == HALT_W) m_mode = M_HALT;
        else                       m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("pc", o_pc, m_pc);
      check("next_seq_pc", o_next_seq_pc, m_pc + 32'd4);
      check("mem_full", o_mem_full, 32'(m_wp == DEPTH));
      check("flush", o_flush, 32'((m_mode == M_RUN) && i_enable && (i_branch_taken || i_jump)));
      if (m_instr_known()) begin
        check("instruction", o_instruction, m_instr());
        check("halt", o_halt, 32'((m_mode == M_HALT) || ((m_mode == M_RUN) && (m_instr() == HALT_W))));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge i_clk);
    #1;
    m_step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic load_word(input logic [31:0] w);
`ifdef IFETCH_BYTE_LOAD_EN
    for (int k = 0; k < 4; k++) begin
      i_load_valid = 1'b1;
      i_load_data  = {24'h0, w[8*k +: 8]};
      tick();
    end
`else
    i_load_valid = 1'b1;
    i_load_data  = w;
    tick();
`endif
    i_load_valid = 1'b0;
  endtask

  task automatic load_program();
    i_enable     = 1'b0;
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    foreach (prog_q[i]) load_word(prog_q[i]);
    i_load_done = 1'b1;
    tick();
    i_load_done = 1'b0;
  endtask

  // ---------------- timeout ----------------
  initial begin
    #300000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    i_reset_n = 1'b0; i_enable = 1'b0; i_stall = 1'b0;
    i_branch_taken = 1'b0; i_branch_pc = '0; i_jump = 1'b0; i_jump_pc = '0;
    i_load_start = 1'b0; i_load_valid = 1'b0; i_load_data = '0; i_load_done = 1'b0;
    m_reset();
    repeat (3) @(posedge i_clk);
    #2;
    i_reset_n = 1'b1;
    cmp_en    = 1'b1;
    #1;
    check("reset_pc", o_pc, 32'h0);
    check("reset_full", o_mem_full, 32'h0);
    check("reset_flush", o_flush, 32'h0);

    // Program ending in HALT: PC trace 0,4,8 then frozen at 8.
    prog_q = '{32'h2001_0005, 32'h2002_0003, HALT_W};
    load_program();
    i_enable = 1'b1;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8};
    for (int i = 0; i < 5; i++) begin
      #1;
      check("halt_trace_pc", o_pc, exp_q.pop_front());
      if (i >= 2) check("halt_trace_halt", o_halt, 32'h1);
      tick();
    end

    // Restart from HALTED; a jump on the HALT cycle redirects instead.
    load_program();
    i_enable = 1'b1;
    tick(); tick();
    #1;
    check("halt_at_8", o_halt, 32'h1);
    i_jump = 1'b1; i_jump_pc = 32'h4;
    #1;
    check("halt_jump_flush", o_flush, 32'h1);
    tick();
    i_jump = 1'b0;
    #1;
    check("halt_jump_pc", o_pc, 32'h4);
    check("halt_jump_halt", o_halt, 32'h0);
    i_enable = 1'b0;
    tick(); tick();
    #1;
    check("disable_hold_pc", o_pc, 32'h4);
    i_enable = 1'b1;
    tick(); tick(); tick();
    i_branch_taken = 1'b1; i_branch_pc = 32'h0;
    #1;
    check("halted_no_flush", o_flush, 32'h0);
    tick();
    i_branch_taken = 1'b0;
    #1;
    check("halted_pc_frozen", o_pc, 32'h8);
    check("halted_halt", o_halt, 32'h1);

    // 32-word straight-line program for redirect tests.
    prog_q.delete();
    for (int i = 0; i < 32; i++) prog_q.push_back(32'h1000 + i);
    load_program();
    i_enable = 1'b1;
    repeat (4) tick();
    #1;
    check("run_pc_10", o_pc, 32'h10);
    i_stall = 1'b1; i_jump = 1'b1; i_jump_pc = 32'h40;
    #1;
    check("stall_jump_flush", o_flush, 32'h1);
    tick();
    #1;
    check("stall_pc_held", o_pc, 32'h10);
    i_stall = 1'b0;
    tick();
    #1;
    check("jump_after_stall", o_pc, 32'h40);
    i_branch_taken = 1'b1; i_branch_pc = 32'h20; i_jump_pc = 32'h80;
    tick();
    i_branch_taken = 1'b0; i_jump = 1'b0;
    #1;
    check("branch_over_jump", o_pc, 32'h20);
    tick();
    #1;
    check("seq_after_branch", o_pc, 32'h24);

    // Reset mid-run at PC 0x0C; program must survive.
    i_jump = 1'b1; i_jump_pc = 32'h0C;
    tick();
    i_jump = 1'b0;
    #1;
    check("pre_reset_pc", o_pc, 32'h0C);
    i_jump = 1'b1; i_jump_pc = 32'h40;
    i_reset_n = 1'b0;
    m_reset();
    #1;
    check("async_reset_pc", o_pc, 32'h0);
    check("async_reset_flush", o_flush, 32'h0);
    check("reset_keeps_mem0", o_instruction, 32'h1000);
    tick(); tick();
    i_jump = 1'b0;
    i_reset_n = 1'b1;
    tick();
    #1;
    check("post_reset_load_hold", o_pc, 32'h0);
    i_load_done = 1'b1;
    tick();
    i_load_done = 1'b0;
    tick();
    #1;
    check("post_reset_pc4", o_pc, 32'h4);
    check("post_reset_mem1", o_instruction, 32'h1001);

`ifdef IFETCH_BYTE_LOAD_EN
    // Little-endian byte assembly; a trailing partial word is dropped.
    i_enable = 1'b0;
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    exp_q = '{32'h78, 32'h56, 32'h34, 32'h12, 32'hAA, 32'hBB, 32'hCC};
    while (exp_q.size() > 0) begin
      i_load_valid = 1'b1;
      i_load_data  = exp_q.pop_front();
      tick();
    end
    i_load_valid = 1'b0;
    i_load_done  = 1'b1;
    tick();
    i_load_done = 1'b0;
    i_enable = 1'b1;
    #1;
    check("byte_word0", o_instruction, 32'h1234_5678);
    tick();
    #1;
    check("byte_partial_dropped", o_instruction, 32'h1001);
`endif

    // Overfill: DEPTH+2 words, pointer saturates, mem[0] intact.
    i_enable = 1'b0;
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      load_word(32'hA000 + i);
      #1;
      if (i == DEPTH - 2) check("not_full_yet", o_mem_full, 32'h0);
      if (i == DEPTH - 1) check("full_at_depth", o_mem_full, 32'h1);
    end
    check("full_after_extra", o_mem_full, 32'h1);
    i_load_done = 1'b1;
    tick();
    i_load_done = 1'b0;
    i_enable = 1'b1;
    #1;
    check("mem0_intact", o_instruction, 32'hA000);
    i_jump = 1'b1; i_jump_pc = 32'h3FC;
    tick();
    i_jump = 1'b0;
    #1;
    check("last_word", o_instruction, 32'hA0FF);
    check("last_word_no_halt", o_halt, 32'h0);
    tick();
    #1;
    check("oob_pc", o_pc, 32'h400);
    check("oob_reads_halt", o_instruction, HALT_W);
    check("oob_halt", o_halt, 32'h1);
    tick();
    #1;
    check("oob_frozen", o_pc, 32'h400);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameters SHALL be: PC_SIZE, 32, program-counter width in bits; INSTRUCTION_SIZE, 32, instruction width; MEM_DEPTH, 256, instruction-memory depth in words (power of two).
REQ-002 Ports (name, direction, width, meaning) SHALL be exactly:
  i_clk  in  1  single clock, rising edge.
  i_reset_n  in  1  reset, asynchronous, active-low.
  i_enable  in  1  global run enable from the debug unit.
  i_stall  in  1  hazard-unit hold: PC frozen.
  i_branch_taken  in  1  branch resolved taken.
  i_branch_pc  in  PC_SIZE  branch target.
  i_jump  in  1  jump decoded.
  i_jump_pc  in  PC_SIZE  jump target.
  i_load_start  in  1  enter load mode and clear the write pointer.
  i_load_valid  in  1  load data beat valid.
  i_load_data  in  INSTRUCTION_SIZE  load beat; only bits [7:0] are used when IFETCH_BYTE_LOAD_EN is defined.
  i_load_done  in  1  leave load mode.
  o_next_seq_pc  out  PC_SIZE  PC+4 of the fetched instruction, for the IF/ID register.
  o_instruction  out  INSTRUCTION_SIZE  fetched instruction.
  o_halt  out  1  fetched instruction is HALT.
  o_flush  out  1  flush request to the IF/ID register.
  o_mem_full  out  1  write pointer reached MEM_DEPTH.
  o_pc  out  PC_SIZE  current PC.

Function
REQ-003 The FSM SHALL have states LOAD, RUN and HALTED; it SHALL leave reset in LOAD.
REQ-004 In any state, i_load_start SHALL enter LOAD, clear the write pointer and clear the PC.
REQ-005 In LOAD, i_load_done SHALL move the FSM to RUN; i_load_start SHALL take priority if both are high in the same cycle.
REQ-006 In LOAD, each i_load_valid word SHALL be written at the write pointer, and the pointer SHALL then increment.
REQ-007 Once the pointer equals MEM_DEPTH, o_mem_full SHALL be 1 and further writes SHALL be dropped; the pointer SHALL NOT wrap.
REQ-008 The instruction read SHALL be asynchronous: o_instruction = mem[o_pc[log2(MEM_DEPTH)+1:2]] in the same cycle, so fetch latency is zero cycles and the IF/ID register adds one.
REQ-009 A PC at or beyond MEM_DEPTH*4 SHALL read the HALT constant.
REQ-010 In RUN, the PC update SHALL follow this priority: !i_enable or i_stall holds; then i_branch_taken loads i_branch_pc; then i_jump loads i_jump_pc; otherwise PC becomes PC+4, modulo 2^PC_SIZE.
REQ-011 o_flush SHALL equal i_branch_taken or i_jump while in RUN and i_enable is high; it is combinational and asserts even when i_stall is high.
REQ-012 o_halt SHALL be 1 when state is RUN and o_instruction equals HALT.
REQ-013 On the next enabled edge after o_halt, the FSM SHALL enter HALTED.
REQ-014 In HALTED the PC SHALL freeze at the HALT address, o_halt SHALL stay 1, and only i_load_start SHALL exit the state.
REQ-015 A branch or jump in the same cycle as HALT SHALL win: the PC is redirected and the FSM stays in RUN.
REQ-016 o_next_seq_pc SHALL equal o_pc + 4 at all times.

Reset
REQ-017 Asserting i_reset_n low SHALL immediately force: state LOAD, PC 0, write pointer 0, o_mem_full 0 and o_flush 0.
REQ-018 Memory contents SHALL NOT be reset, so o_instruction during reset reflects mem[0].
REQ-019 Reset asserted mid-load SHALL abandon the load, and mid-run SHALL abandon execution, without partial writes on the reset edge.

Configuration
REQ-020 With IFETCH_BYTE_LOAD_EN defined, load beats SHALL be bytes, assembled little-endian with 4 beats per word; the word SHALL be written on the 4th beat and the pointer then increments.
REQ-021 With IFETCH_BYTE_LOAD_EN defined, a partial word at i_load_done SHALL be discarded.
REQ-022 Without IFETCH_BYTE_LOAD_EN, each beat SHALL write one full word.

Structure
REQ-023 The shared package/header SHALL hold the HALT constant (32'hFFFFFFFF), NOP (32'h0), the FSM state encodings and the defaults for PC_SIZE, INSTRUCTION_SIZE and MEM_DEPTH.
REQ-024 The memory SHALL be a sub-module instruction_memory with one synchronous write port and one asynchronous read port.

Verification
REQ-025 Load words 0x20010005, 0x20020003, then HALT, then run -> o_pc steps 0, 4, 8; o_halt=1 at PC 8; PC frozen at 8 thereafter.
REQ-026 In RUN at PC 0x10, i_stall=1 with i_jump=1 and i_jump_pc=0x40 -> o_flush=1 and PC held at 0x10; after stall release with jump still high, PC=0x40.
REQ-027 i_branch_taken=1 (i_branch_pc=0x20) together with i_jump=1 (i_jump_pc=0x80) -> PC=0x20 on the next edge.
REQ-028 Write MEM_DEPTH+2 words -> o_mem_full=1 after word MEM_DEPTH; the last two words are not written; mem[0] is intact.
REQ-029 Byte mode: load bytes 0x78, 0x56, 0x34, 0x12 -> mem[0]=0x12345678; with 3 bytes then i_load_done -> mem[1] unchanged.
REQ-030 i_reset_n low at mid-run PC 0x0C -> PC=0 and state LOAD immediately; previously loaded program still readable.
